// File: rtl/lsmitll_demerget_pkg.sv
// Shared types and default parameters for the toggle-stream de-merger.
package lsmitll_demerget_pkg;

  typedef enum logic {
    DM_RR    = 1'b0,
    DM_STEER = 1'b1
  } dispatch_mode_e;

  localparam int MIN_GAP_DEF = 3;
  localparam int OUT_GAP_DEF = 4;
  localparam int PEND_W_DEF  = 3;
  localparam int VIOL_MAX    = 255;

endpackage

// File: rtl/lsmitll_demerget_port.sv
// One paced toggle output: spacing counter, pending-pulse counter and overflow strobe.
module lsmitll_demerget_port #(
  parameter int OUT_GAP = 4,
  parameter int PEND_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_arrive,
  output logic              o_tog,
  output logic [PEND_W-1:0] o_pend,
  output logic              o_ovf
);

  localparam int SP_W = $clog2(OUT_GAP + 1);
  localparam logic [SP_W-1:0]   SP_MAX   = SP_W'(OUT_GAP);
  localparam logic [SP_W-1:0]   SP_READY = SP_W'(OUT_GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [SP_W-1:0]   r_space;
  logic [PEND_W-1:0] r_pend;
  logic              r_tog;

  logic w_ready;
  logic w_full;
  logic w_acc;
  logic w_fire;

  // Counter holds 0 in the cycle after a toggle, so ready at OUT_GAP-1 gives OUT_GAP-edge spacing.
  assign w_ready = (r_space >= SP_READY);
  assign w_full  = (r_pend == PEND_MAX);
  assign w_acc   = i_arrive & ~w_full;
  assign w_fire  = w_ready & (w_acc | (r_pend != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_space <= SP_MAX;
      r_pend  <= '0;
      r_tog   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_tog   <= ~r_tog;
        r_space <= '0;
      end else if (r_space < SP_MAX) begin
        r_space <= r_space + 1'b1;
      end
      if (w_acc && !w_fire) begin
        r_pend <= r_pend + 1'b1;
      end else if (!w_acc && w_fire) begin
        r_pend <= r_pend - 1'b1;
      end
    end
  end

  assign o_tog  = r_tog;
  assign o_pend = r_pend;
  assign o_ovf  = i_arrive & w_full;

endmodule

// File: rtl/lsmitll_demerget_sync.sv
// Toggle-stream de-merger: sync, pulse detect, gap policing, A/B dispatch, violation count.
// Define LSMITLL_DEMERGET_VIOL_LOG_EN to report violations (simulation only).
module lsmitll_demerget_sync
  import lsmitll_demerget_pkg::*;
#(
  parameter int MIN_GAP = MIN_GAP_DEF,
  parameter int OUT_GAP = OUT_GAP_DEF,
  parameter int PEND_W  = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_in,
  input  logic              sel_mode,
  input  logic              route,
  output logic              a_out,
  output logic              b_out,
  output logic [PEND_W-1:0] pend_a,
  output logic [PEND_W-1:0] pend_b,
  output logic              err,
  output logic [7:0]        viol_cnt
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_OK  = GAP_W'(MIN_GAP - 1);

  logic             r_s1, r_s2, r_s3;
  logic [GAP_W-1:0] r_gap;
  logic             r_rr;
  logic             r_err;
  logic [7:0]       r_viol;

  dispatch_mode_e w_mode;
  logic w_pulse;
  logic w_gap_viol;
  logic w_acc;
  logic w_to_b;
  logic w_ovf_a, w_ovf_b;
  logic w_viol;

  // r_gap reads 0 the cycle after a pulse, so MIN_GAP-1 here means MIN_GAP cycles elapsed.
  assign w_pulse    = r_s2 ^ r_s3;
  assign w_gap_viol = w_pulse & (r_gap < GAP_OK);
  assign w_acc      = w_pulse & ~w_gap_viol;
  assign w_mode     = dispatch_mode_e'(sel_mode);
  assign w_to_b     = (w_mode == DM_STEER) ? route : r_rr;
  assign w_viol     = w_gap_viol | w_ovf_a | w_ovf_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_gap  <= GAP_MAX;
      r_rr   <= 1'b0;
      r_err  <= 1'b0;
      r_viol <= 8'd0;
    end else begin
      r_s1 <= q_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_pulse) begin
        r_gap <= '0;
      end else if (r_gap < GAP_MAX) begin
        r_gap <= r_gap + 1'b1;
      end
      if (w_acc && (w_mode == DM_RR)) begin
        r_rr <= ~r_rr;
      end
      if (w_viol) begin
        r_err <= 1'b1;
        if (r_viol != 8'(VIOL_MAX)) begin
          r_viol <= r_viol + 8'd1;
        end
      end
    end
  end

  lsmitll_demerget_port #(
    .OUT_GAP (OUT_GAP),
    .PEND_W  (PEND_W)
  ) u_port_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_arrive (w_acc & ~w_to_b),
    .o_tog    (a_out),
    .o_pend   (pend_a),
    .o_ovf    (w_ovf_a)
  );

  lsmitll_demerget_port #(
    .OUT_GAP (OUT_GAP),
    .PEND_W  (PEND_W)
  ) u_port_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_arrive (w_acc & w_to_b),
    .o_tog    (b_out),
    .o_pend   (pend_b),
    .o_ovf    (w_ovf_b)
  );

  assign err      = r_err;
  assign viol_cnt = r_viol;

`ifdef LSMITLL_DEMERGET_VIOL_LOG_EN
  always @(posedge clk) begin
    if (rst_n && w_viol) begin
      if (w_gap_viol)
        $display("gap Violation of critical timing in module %m; %0t ps.", $time);
      if (w_ovf_a)
        $display("overflow A Violation of critical timing in module %m; %0t ps.", $time);
      if (w_ovf_b)
        $display("overflow B Violation of critical timing in module %m; %0t ps.", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_lsmitll_demerget_sync.sv
// Directed bench for lsmitll_demerget_sync with hand-derived toggle counts, timing and flags.
module tb_lsmitll_demerget_sync;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       q_in     = 1'b0;
  logic       sel_mode = 1'b0;
  logic       route    = 1'b0;
  logic       a_out, b_out, err;
  logic [2:0] pend_a, pend_b;
  logic [7:0] viol_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int   a_cnt = 0, b_cnt = 0, pmax_a = 0, pmax_b = 0;
  int   a_times[$];
  logic a_prev = 1'b0, b_prev = 1'b0;
  int   t0;

  lsmitll_demerget_sync dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .q_in     (q_in),
    .sel_mode (sel_mode),
    .route    (route),
    .a_out    (a_out),
    .b_out    (b_out),
    .pend_a   (pend_a),
    .pend_b   (pend_b),
    .err      (err),
    .viol_cnt (viol_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Toggle/peak observer, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (a_out !== a_prev) begin
      a_cnt++;
      a_times.push_back(cyc);
    end
    if (b_out !== b_prev) b_cnt++;
    a_prev = a_out;
    b_prev = b_out;
    if (int'(pend_a) > pmax_a) pmax_a = int'(pend_a);
    if (int'(pend_b) > pmax_b) pmax_b = int'(pend_b);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    a_cnt  = 0;
    b_cnt  = 0;
    pmax_a = 0;
    pmax_b = 0;
    a_times.delete();
    a_prev = a_out;
    b_prev = b_out;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q_in  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
  endtask

  task automatic pulse_train(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      q_in = ~q_in;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic rr_step(input int old_a, input int old_b, input int new_a, input int new_b);
    @(negedge clk);
    q_in = ~q_in;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rr_hold_a", int'(a_out), old_a);
    check("rr_hold_b", int'(b_out), old_b);
    @(posedge clk);
    #1;
    check("rr_new_a", int'(a_out), new_a);
    check("rr_new_b", int'(b_out), new_b);
    repeat (7) @(posedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_a_out", int'(a_out), 0);
    check("rst_b_out", int'(b_out), 0);
    check("rst_pend_a", int'(pend_a), 0);
    check("rst_pend_b", int'(pend_b), 0);
    check("rst_err", int'(err), 0);
    check("rst_viol", int'(viol_cnt), 0);

    // Round-robin A,B,A,B with 3-edge latency
    sel_mode = 1'b0;
    rr_step(0, 0, 1, 0);
    rr_step(1, 0, 1, 1);
    rr_step(1, 1, 0, 1);
    rr_step(0, 1, 0, 0);
    check("rr_err", int'(err), 0);

    // Steer to A, pulses 3 apart: toggles at t, t+4, t+8
    @(negedge clk);
    sel_mode = 1'b1;
    route    = 1'b0;
    clr_mon();
    @(negedge clk);
    t0 = cyc;
    q_in = ~q_in;
    repeat (2) @(negedge clk);
    pulse_train(2, 3);
    repeat (20) @(negedge clk);
    check("steer_a_cnt", a_cnt, 3);
    check("steer_b_cnt", b_cnt, 0);
    check("steer_pmax_a", pmax_a, 1);
    check("steer_t0", (a_times.size() > 0) ? a_times[0] : -1, t0 + 3);
    check("steer_dt1", (a_times.size() > 1) ? a_times[1] - a_times[0] : -1, 4);
    check("steer_dt2", (a_times.size() > 2) ? a_times[2] - a_times[0] : -1, 8);
    check("steer_err", int'(err), 0);

    // Two pulses 2 apart: second dropped; RR pointer is back at A
    @(negedge clk);
    sel_mode = 1'b0;
    clr_mon();
    pulse_train(2, 2);
    repeat (10) @(negedge clk);
    check("gap_a_cnt", a_cnt, 1);
    check("gap_b_cnt", b_cnt, 0);
    check("gap_err", int'(err), 1);
    check("gap_viol", int'(viol_cnt), 1);

    // Overflow on B: 36 pulses 3 apart, pend saturates at 7, drops at pulses 29 and 33
    do_reset();
    sel_mode = 1'b1;
    route    = 1'b1;
    pulse_train(36, 3);
    repeat (60) @(negedge clk);
    check("ovf_pmax_b", pmax_b, 7);
    check("ovf_viol", int'(viol_cnt), 2);
    check("ovf_err", int'(err), 1);
    check("ovf_b_cnt", b_cnt, 34);
    check("ovf_a_cnt", a_cnt, 0);
    check("ovf_pend_b_end", int'(pend_b), 0);

    // Reset while pend_a = 3 (after the 10th pulse, 3 apart, into A)
    do_reset();
    sel_mode = 1'b1;
    route    = 1'b0;
    pulse_train(9, 3);
    @(negedge clk);
    q_in = ~q_in;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_pend_a", int'(pend_a), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_a", int'(a_out), 0);
    check("mid_rst_b", int'(b_out), 0);
    check("mid_rst_pend_a", int'(pend_a), 0);
    check("mid_rst_pend_b", int'(pend_b), 0);
    check("mid_rst_err", int'(err), 0);
    check("mid_rst_viol", int'(viol_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clr_mon();
    repeat (30) @(negedge clk);
    check("mid_post_a_cnt", a_cnt, 0);
    check("mid_post_b_cnt", b_cnt, 0);
    check("mid_post_pend_a", int'(pend_a), 0);

    // 301 toggles 2 apart: one accepted, 300 gap violations
    do_reset();
    sel_mode = 1'b0;
    pulse_train(301, 2);
    repeat (10) @(negedge clk);
    check("sat_viol", int'(viol_cnt), 255);
    check("sat_err", int'(err), 1);
    check("sat_outputs", a_cnt + b_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
